// File: rtl/usb_ep_router_if.sv
// Handshake-layer side of usb_ep_router: token stream, host->device bytes and device->host bytes.
interface usb_ep_router_if;
  logic [23:0] token_in;
  logic        token_in_strb;
  logic [7:0]  pid_in;
  logic [7:0]  data_in;
  logic        data_in_strb;
  logic        data_in_end;
  logic        data_in_fail;
  logic [7:0]  data_o;
  logic        data_o_start_stop;
  logic        data_o_strb;
  logic        data_o_fail;

  modport master (
    output token_in, token_in_strb, pid_in, data_in, data_in_strb, data_in_end, data_in_fail,
    output data_o_strb, data_o_fail,
    input  data_o, data_o_start_stop
  );

  modport slave (
    input  token_in, token_in_strb, pid_in, data_in, data_in_strb, data_in_end, data_in_fail,
    input  data_o_strb, data_o_fail,
    output data_o, data_o_start_stop
  );
endinterface

// File: rtl/usb_ep_router.sv
// Routes USB tokens and data between the handshake layer and N_EP endpoint channels.
// Optional IN-response watchdog enabled by defining USB_EP_ROUTER_TIMEOUT_EN.
module usb_ep_router #(
  parameter int unsigned N_EP    = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [6:0]          dev_addr,
  usb_ep_router_if.slave      hs,
  output logic [23:0]         ep_token,
  output logic [N_EP-1:0]     ep_token_strb,
  output logic [7:0]          ep_pid,
  output logic [7:0]          ep_data,
  output logic [N_EP-1:0]     ep_data_strb,
  output logic [N_EP-1:0]     ep_data_end,
  output logic [N_EP-1:0]     ep_data_fail,
  input  logic [8*N_EP-1:0]   ep_tx_data,
  input  logic [N_EP-1:0]     ep_tx_start_stop,
  output logic [N_EP-1:0]     ep_tx_strb,
  output logic [N_EP-1:0]     ep_tx_fail,
  output logic [3:0]          active_ep
);

  localparam logic [7:0] PID_SOF   = 8'hA5;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_IN    = 8'h69;

  if (N_EP < 1 || N_EP > 16 || TIMEOUT < 1) begin : g_cfg_check
    $error("usb_ep_router: N_EP must be 1..16 and TIMEOUT at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_DATA,
    S_DROP,
    S_TX_WAIT,
    S_TX_DATA
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      sel_q, sel_d;
  logic [N_EP-1:0] sel_oh, endp_oh;
  logic [N_EP-1:0] tok_strb_d, dstrb_d, dend_d, dfail_d, tx_fail_d, tx_fail_q;
  logic [7:0]      sel_tx_data;
  logic            sel_ss;
  logic [7:0]      tok_pid;
  logic [3:0]      tok_endp;
  logic            tok_match, tok_new, tx_on;

`ifdef USB_EP_ROUTER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign tok_pid   = hs.token_in[7:0];
  assign tok_endp  = hs.token_in[18:15];
  assign tok_match = (hs.token_in[14:8] == dev_addr) && (32'(tok_endp) < N_EP);
  // Only real transaction tokens retarget the router; SOF and stray PIDs never abort.
  assign tok_new   = hs.token_in_strb &&
                     (tok_pid == PID_OUT || tok_pid == PID_SETUP || tok_pid == PID_IN);

  // Channel select decode and selected-endpoint transmit mux
  always_comb begin : sel_mux
    sel_oh      = '0;
    endp_oh     = '0;
    sel_tx_data = 8'h00;
    sel_ss      = 1'b0;
    for (int k = 0; k < int'(N_EP); k++) begin
      endp_oh[k] = (tok_endp == 4'(k));
      if (sel_q == 4'(k)) begin
        sel_oh[k]   = 1'b1;
        sel_tx_data = ep_tx_data[8*k +: 8];
        sel_ss      = ep_tx_start_stop[k];
      end
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    sel_d      = sel_q;
    tok_strb_d = '0;
    dstrb_d    = '0;
    dend_d     = '0;
    dfail_d    = '0;
    tx_fail_d  = '0;
`ifdef USB_EP_ROUTER_TIMEOUT_EN
    cnt_d      = '0;
`endif
    case (state_q)
      S_RX_DATA: begin
        if (hs.data_in_strb) dstrb_d = sel_oh;
        if (hs.data_in_end)  dend_d  = sel_oh;
        if (hs.data_in_fail) dfail_d = sel_oh;
        if (hs.data_in_end || hs.data_in_fail) state_d = S_IDLE;
        else if (tok_new)                      dfail_d = sel_oh;
      end
      S_DROP: begin
        if (hs.data_in_end || hs.data_in_fail) state_d = S_IDLE;
      end
      S_TX_WAIT: begin
        if (sel_ss) state_d = S_TX_DATA;
`ifdef USB_EP_ROUTER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tx_fail_d = sel_oh;
          state_d   = S_IDLE;
        end
        cnt_d = cnt_q + 1'b1;
`endif
        if (tok_new) tx_fail_d = sel_oh;
      end
      S_TX_DATA: begin
        if (!sel_ss || hs.data_o_fail) state_d   = S_IDLE;
        else if (tok_new)              tx_fail_d = sel_oh;
      end
      default: ;
    endcase

    if (hs.token_in_strb && tok_pid == PID_SOF) tok_strb_d = '1;

    // Token decode wins over whatever the current transaction wanted next
    if (tok_new) begin
      if (tok_match) begin
        sel_d      = tok_endp;
        tok_strb_d = endp_oh;
        state_d    = (tok_pid == PID_IN) ? S_TX_WAIT : S_RX_DATA;
`ifdef USB_EP_ROUTER_TIMEOUT_EN
        cnt_d      = '0;
`endif
      end else begin
        state_d = (tok_pid == PID_IN) ? S_IDLE : S_DROP;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin : regs
    if (!nrst) begin
      state_q       <= S_IDLE;
      sel_q         <= 4'd0;
      ep_token      <= 24'h0;
      ep_token_strb <= '0;
      ep_pid        <= 8'h00;
      ep_data       <= 8'h00;
      ep_data_strb  <= '0;
      ep_data_end   <= '0;
      ep_data_fail  <= '0;
      tx_fail_q     <= '0;
`ifdef USB_EP_ROUTER_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      if (hs.token_in_strb) ep_token <= hs.token_in;
      ep_token_strb <= tok_strb_d;
      ep_pid        <= hs.pid_in;
      ep_data       <= hs.data_in;
      ep_data_strb  <= dstrb_d;
      ep_data_end   <= dend_d;
      ep_data_fail  <= dfail_d;
      tx_fail_q     <= tx_fail_d;
`ifdef USB_EP_ROUTER_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  // Transmit path is combinational so the PHY's NXT strobe is honoured in the same cycle
  assign tx_on                = (state_q == S_TX_DATA);
  assign hs.data_o            = tx_on ? sel_tx_data : 8'h00;
  assign hs.data_o_start_stop = tx_on & sel_ss;
  assign ep_tx_strb           = (tx_on && hs.data_o_strb) ? sel_oh : '0;
  assign ep_tx_fail           = tx_fail_q | ((tx_on && hs.data_o_fail) ? sel_oh : '0);
  assign active_ep            = sel_q;

endmodule

// File: tb/tb_usb_ep_router.sv
// Self-checking bench for usb_ep_router: directed scenarios plus randomized traffic against a reference model.
module tb_usb_ep_router;
  localparam int unsigned N_EP    = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [7:0] SOF = 8'hA5, OUT = 8'hE1, SETUP = 8'h2D, IN = 8'h69;
  localparam int PH_IDLE = 0, PH_RX = 1, PH_DROP = 2, PH_WAIT = 3, PH_SEND = 4;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic [6:0]       dev_addr;
  logic [23:0]      ep_token;
  logic [N_EP-1:0]  ep_token_strb, ep_data_strb, ep_data_end, ep_data_fail;
  logic [7:0]       ep_pid, ep_data;
  logic [8*N_EP-1:0] ep_tx_data;
  logic [N_EP-1:0]  ep_tx_start_stop, ep_tx_strb, ep_tx_fail;
  logic [3:0]       active_ep;

  int errors = 0;
  int checks = 0;

  usb_ep_router_if hs ();

  usb_ep_router #(.N_EP(N_EP), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .dev_addr         (dev_addr),
    .hs               (hs),
    .ep_token         (ep_token),
    .ep_token_strb    (ep_token_strb),
    .ep_pid           (ep_pid),
    .ep_data          (ep_data),
    .ep_data_strb     (ep_data_strb),
    .ep_data_end      (ep_data_end),
    .ep_data_fail     (ep_data_fail),
    .ep_tx_data       (ep_tx_data),
    .ep_tx_start_stop (ep_tx_start_stop),
    .ep_tx_strb       (ep_tx_strb),
    .ep_tx_fail       (ep_tx_fail),
    .active_ep        (active_ep)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk_tok(logic [7:0] pid, logic [6:0] addr, logic [3:0] endp);
    return {5'h0, endp, addr, pid};
  endfunction

  task automatic clr_in();
    hs.token_in = 24'h0; hs.token_in_strb = 1'b0; hs.pid_in = 8'h00;
    hs.data_in = 8'h00; hs.data_in_strb = 1'b0; hs.data_in_end = 1'b0; hs.data_in_fail = 1'b0;
    hs.data_o_strb = 1'b0; hs.data_o_fail = 1'b0;
    ep_tx_data = '0; ep_tx_start_stop = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_tok(logic [7:0] pid, logic [6:0] addr, logic [3:0] endp);
    hs.token_in = mk_tok(pid, addr, endp); hs.token_in_strb = 1'b1;
    step();
    hs.token_in_strb = 1'b0;
  endtask

  task automatic test_reset();
    clr_in(); dev_addr = 7'd5; nrst = 1'b0;
    #12;
    checks++;
    if ({ep_token, ep_pid, ep_data} !== 40'h0) begin
      errors++; $display("FAIL reset_regs got=%h exp=0", {ep_token, ep_pid, ep_data});
    end
    checks++;
    if ({ep_token_strb, ep_data_strb, ep_data_end, ep_data_fail, ep_tx_strb, ep_tx_fail} !== 24'h0) begin
      errors++; $display("FAIL reset_strobes got=%h exp=0",
        {ep_token_strb, ep_data_strb, ep_data_end, ep_data_fail, ep_tx_strb, ep_tx_fail});
    end
    checks++;
    if ({hs.data_o, hs.data_o_start_stop, active_ep} !== 13'h0) begin
      errors++; $display("FAIL reset_tx got=%h exp=0", {hs.data_o, hs.data_o_start_stop, active_ep});
    end
    @(negedge clk) nrst = 1'b1;
    step();
  endtask

  task automatic test_out_rx();
    logic [7:0] b [3];
    b = '{8'h11, 8'h22, 8'h33};
    send_tok(OUT, 7'd5, 4'd2);
    checks++;
    if ({ep_token_strb, ep_token, active_ep} !== {4'b0100, mk_tok(OUT, 7'd5, 4'd2), 4'd2}) begin
      errors++; $display("FAIL out_token got=%b/%h/%0d exp=0100/%h/2", ep_token_strb, ep_token, active_ep,
        mk_tok(OUT, 7'd5, 4'd2));
    end
    hs.pid_in = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      hs.data_in = b[i]; hs.data_in_strb = 1'b1;
      step();
      checks++;
      if ({ep_data_strb, ep_data, ep_pid, ep_token_strb, ep_data_end} !== {4'b0100, b[i], 8'hC3, 4'b0, 4'b0}) begin
        errors++; $display("FAIL out_byte%0d got=%b/%h/%h/%b exp=0100/%h/c3/0000", i,
          ep_data_strb, ep_data, ep_pid, ep_token_strb, b[i]);
      end
    end
    hs.data_in_strb = 1'b0; hs.data_in_end = 1'b1;
    step();
    checks++;
    if ({ep_data_end, ep_data_strb, ep_data_fail} !== {4'b0100, 4'b0, 4'b0}) begin
      errors++; $display("FAIL out_end got=%b/%b/%b exp=0100/0000/0000", ep_data_end, ep_data_strb, ep_data_fail);
    end
    hs.data_in_end = 1'b0; hs.data_in_strb = 1'b1; hs.data_in = 8'h44;
    step();
    checks++;
    if (ep_data_strb !== 4'b0) begin
      errors++; $display("FAIL out_idle_after got=%b exp=0000", ep_data_strb);
    end
    clr_in();
  endtask

  task automatic test_in_tx();
    send_tok(IN, 7'd5, 4'd1);
    checks++;
    if (ep_token_strb !== 4'b0010) begin
      errors++; $display("FAIL in_token got=%b exp=0010", ep_token_strb);
    end
    ep_tx_data = {8'h5A, 8'h3C, 8'hA0, 8'h77}; ep_tx_start_stop = 4'b1010;
    #1;
    checks++;
    if ({hs.data_o, hs.data_o_start_stop} !== 9'h0) begin
      errors++; $display("FAIL in_wait_quiet got=%h/%b exp=00/0", hs.data_o, hs.data_o_start_stop);
    end
    step();
    hs.data_o_strb = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({hs.data_o, hs.data_o_start_stop, ep_tx_strb} !== {8'hA0, 1'b1, 4'b0010}) begin
        errors++; $display("FAIL in_nxt%0d got=%h/%b/%b exp=a0/1/0010", i, hs.data_o, hs.data_o_start_stop, ep_tx_strb);
      end
      step();
    end
    hs.data_o_strb = 1'b0; ep_tx_start_stop = 4'b1000;
    #1;
    checks++;
    if ({hs.data_o_start_stop, ep_tx_strb} !== 5'b0) begin
      errors++; $display("FAIL in_fall got=%b/%b exp=0/0000", hs.data_o_start_stop, ep_tx_strb);
    end
    step();
    ep_tx_start_stop = 4'b0010; hs.data_o_strb = 1'b1;
    step();
    checks++;
    if ({hs.data_o, hs.data_o_start_stop, ep_tx_strb} !== 13'h0) begin
      errors++; $display("FAIL in_idle_after got=%h/%b/%b exp=0", hs.data_o, hs.data_o_start_stop, ep_tx_strb);
    end
    clr_in();
  endtask

  task automatic test_drop();
    logic [6:0] addrs [2];
    logic [3:0] endps [2];
    addrs = '{7'd6, 7'd5}; endps = '{4'd0, 4'd9};
    for (int i = 0; i < 2; i++) begin
      send_tok(OUT, addrs[i], endps[i]);
      checks++;
      if (ep_token_strb !== 4'b0) begin
        errors++; $display("FAIL drop%0d_token got=%b exp=0000", i, ep_token_strb);
      end
      hs.data_in = 8'h5C; hs.data_in_strb = 1'b1; hs.data_in_end = 1'b1;
      step();
      checks++;
      if ({ep_data_strb, ep_data_end, ep_data_fail} !== 12'h0) begin
        errors++; $display("FAIL drop%0d_data got=%b/%b/%b exp=0", i, ep_data_strb, ep_data_end, ep_data_fail);
      end
      hs.data_in_strb = 1'b0; hs.data_in_end = 1'b0;
    end
    send_tok(OUT, 7'd5, 4'd0);
    checks++;
    if (ep_token_strb !== 4'b0001) begin
      errors++; $display("FAIL drop_recover_token got=%b exp=0001", ep_token_strb);
    end
    hs.data_in = 8'h7E; hs.data_in_strb = 1'b1; hs.data_in_end = 1'b1;
    step();
    checks++;
    if ({ep_data_strb, ep_data_end, ep_data} !== {4'b0001, 4'b0001, 8'h7E}) begin
      errors++; $display("FAIL drop_recover_data got=%b/%b/%h exp=0001/0001/7e", ep_data_strb, ep_data_end, ep_data);
    end
    clr_in();
  endtask

  task automatic test_sof_during_rx();
    send_tok(OUT, 7'd5, 4'd3);
    hs.data_in = 8'h5E; hs.data_in_strb = 1'b1;
    hs.token_in = mk_tok(SOF, 7'($urandom), 4'($urandom)); hs.token_in_strb = 1'b1;
    step();
    checks++;
    if ({ep_token_strb, ep_data_strb, ep_data_fail} !== {4'b1111, 4'b1000, 4'b0}) begin
      errors++; $display("FAIL sof_rx got=%b/%b/%b exp=1111/1000/0000", ep_token_strb, ep_data_strb, ep_data_fail);
    end
    hs.token_in_strb = 1'b0; hs.data_in = 8'h6F; hs.data_in_end = 1'b1;
    step();
    checks++;
    if ({ep_token_strb, ep_data_strb, ep_data_end, ep_data} !== {4'b0, 4'b1000, 4'b1000, 8'h6F}) begin
      errors++; $display("FAIL sof_rx_continue got=%b/%b/%b/%h exp=0000/1000/1000/6f",
        ep_token_strb, ep_data_strb, ep_data_end, ep_data);
    end
    clr_in();
  endtask

  task automatic test_retry();
    send_tok(IN, 7'd5, 4'd3);
    step();
    send_tok(SETUP, 7'd5, 4'd0);
    checks++;
    if ({ep_tx_fail, ep_token_strb, active_ep} !== {4'b1000, 4'b0001, 4'd0}) begin
      errors++; $display("FAIL retry_tx_abort got=%b/%b/%0d exp=1000/0001/0", ep_tx_fail, ep_token_strb, active_ep);
    end
    hs.data_in = 8'h80; hs.data_in_strb = 1'b1;
    step();
    checks++;
    if ({ep_tx_fail, ep_data_strb} !== {4'b0, 4'b0001}) begin
      errors++; $display("FAIL retry_rx_state got=%b/%b exp=0000/0001", ep_tx_fail, ep_data_strb);
    end
    hs.data_in_strb = 1'b0;
    send_tok(OUT, 7'd5, 4'd1);
    checks++;
    if ({ep_data_fail, ep_token_strb} !== {4'b0001, 4'b0010}) begin
      errors++; $display("FAIL retry_rx_abort got=%b/%b exp=0001/0010", ep_data_fail, ep_token_strb);
    end
    hs.data_in_end = 1'b1;
    step();
    checks++;
    if ({ep_data_end, ep_data_fail} !== {4'b0010, 4'b0}) begin
      errors++; $display("FAIL retry_new_end got=%b/%b exp=0010/0000", ep_data_end, ep_data_fail);
    end
    clr_in();
  endtask

  task automatic test_tx_wait();
    logic [3:0] exp;
    send_tok(IN, 7'd5, 4'd0);
`ifdef USB_EP_ROUTER_TIMEOUT_EN
    for (int k = 1; k <= 17; k++) begin
      step();
      exp = (k == 16) ? 4'b0001 : 4'b0000;
      checks++;
      if (ep_tx_fail !== exp) begin
        errors++; $display("FAIL timeout_cycle%0d got=%b exp=%b", k, ep_tx_fail, exp);
      end
    end
    ep_tx_start_stop = 4'b0001; ep_tx_data = 32'h0000_0099;
    step();
    checks++;
    if (hs.data_o_start_stop !== 1'b0) begin
      errors++; $display("FAIL timeout_idle got=%b exp=0", hs.data_o_start_stop);
    end
`else
    for (int k = 1; k <= 40; k++) begin
      step();
      exp = 4'b0000;
      checks++;
      if (ep_tx_fail !== exp) begin
        errors++; $display("FAIL wait_forever_cycle%0d got=%b exp=%b", k, ep_tx_fail, exp);
      end
    end
    ep_tx_start_stop = 4'b0001; ep_tx_data = 32'h0000_0099;
    step();
    checks++;
    if ({hs.data_o, hs.data_o_start_stop} !== {8'h99, 1'b1}) begin
      errors++; $display("FAIL wait_forever_tx got=%h/%b exp=99/1", hs.data_o, hs.data_o_start_stop);
    end
    ep_tx_start_stop = 4'b0000;
    step();
`endif
    clr_in();
  endtask

  task automatic test_async_reset();
    send_tok(IN, 7'd5, 4'd2);
    ep_tx_start_stop = 4'b0100; ep_tx_data = 32'h00C4_0000;
    step();
    hs.data_o_strb = 1'b1;
    #1;
    checks++;
    if ({hs.data_o, ep_tx_strb} !== {8'hC4, 4'b0100}) begin
      errors++; $display("FAIL areset_pre got=%h/%b exp=c4/0100", hs.data_o, ep_tx_strb);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({hs.data_o, hs.data_o_start_stop, ep_token, active_ep, ep_token_strb, ep_tx_strb, ep_tx_fail} !== 53'h0) begin
      errors++; $display("FAIL areset_outputs got=%h/%b/%h/%0d/%b/%b/%b exp=0", hs.data_o, hs.data_o_start_stop,
        ep_token, active_ep, ep_token_strb, ep_tx_strb, ep_tx_fail);
    end
    clr_in();
    @(negedge clk) nrst = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int ph, nph, tgt, ntgt, endp, waited;
    logic [3:0] pend, tgt_bit, e_ts, e_ds, e_de, e_df, e_tf, e_txs, e_txf;
    logic [7:0] e_do, pid;
    logic e_ss, is_tok;
    logic [7:0] pids [6];
    pids = '{SOF, OUT, SETUP, IN, 8'hD2, 8'h4B};
    ph = PH_IDLE; tgt = 0; pend = '0; waited = 0;
    for (int n = 0; n < 1500; n++) begin
      pid = pids[$urandom_range(0, 5)];
      hs.token_in_strb = ($urandom_range(0, 5) == 0);
      hs.token_in = {5'($urandom), 4'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0) ? 7'd6 : 7'd5, pid};
      hs.pid_in = 8'($urandom); hs.data_in = 8'($urandom);
      hs.data_in_strb = 1'($urandom_range(0, 1));
      hs.data_in_end  = ($urandom_range(0, 9) == 0);
      hs.data_in_fail = ($urandom_range(0, 29) == 0);
      for (int k = 0; k < int'(N_EP); k++) if ($urandom_range(0, 3) == 0) ep_tx_start_stop[k] = ~ep_tx_start_stop[k];
      ep_tx_data = 32'($urandom);
      hs.data_o_strb = 1'($urandom_range(0, 1));
      hs.data_o_fail = ($urandom_range(0, 24) == 0);
      #1;
      // what the handshake layer should see right now
      tgt_bit = 4'b0001 << tgt;
      e_do = 8'h00; e_ss = 1'b0; e_txs = 4'b0; e_txf = pend;
      if (ph == PH_SEND) begin
        e_do = ep_tx_data[8*tgt +: 8];
        e_ss = ep_tx_start_stop[tgt];
        if (hs.data_o_strb) e_txs = tgt_bit;
        if (hs.data_o_fail) e_txf = pend | tgt_bit;
      end
      checks++;
      if ({hs.data_o, hs.data_o_start_stop} !== {e_do, e_ss}) begin
        errors++; $display("FAIL rnd%0d_tx got=%h/%b exp=%h/%b", n, hs.data_o, hs.data_o_start_stop, e_do, e_ss);
      end
      checks++;
      if ({ep_tx_strb, ep_tx_fail} !== {e_txs, e_txf}) begin
        errors++; $display("FAIL rnd%0d_txstrb got=%b/%b exp=%b/%b", n, ep_tx_strb, ep_tx_fail, e_txs, e_txf);
      end
      // consequences that appear after the coming clock edge
      endp = int'(hs.token_in[18:15]);
      is_tok = hs.token_in_strb && (pid == OUT || pid == SETUP || pid == IN);
      e_ts = '0; e_ds = '0; e_de = '0; e_df = '0; e_tf = '0;
      nph = ph; ntgt = tgt;
      if (ph == PH_RX) begin
        if (hs.data_in_strb) e_ds = tgt_bit;
        if (hs.data_in_end)  e_de = tgt_bit;
        if (hs.data_in_fail || (is_tok && !hs.data_in_end)) e_df = tgt_bit;
        if (hs.data_in_end || hs.data_in_fail) nph = PH_IDLE;
      end else if (ph == PH_DROP) begin
        if (hs.data_in_end || hs.data_in_fail) nph = PH_IDLE;
      end else if (ph == PH_WAIT) begin
        if (ep_tx_start_stop[tgt]) nph = PH_SEND;
`ifdef USB_EP_ROUTER_TIMEOUT_EN
        else if (waited == int'(TIMEOUT) - 1) begin e_tf = tgt_bit; nph = PH_IDLE; end
`endif
        waited++;
        if (is_tok) e_tf = tgt_bit;
      end else if (ph == PH_SEND) begin
        if (!ep_tx_start_stop[tgt] || hs.data_o_fail) nph = PH_IDLE;
        else if (is_tok) e_tf = tgt_bit;
      end
      if (hs.token_in_strb && pid == SOF) e_ts = 4'hF;
      if (is_tok) begin
        if (hs.token_in[14:8] == dev_addr && endp < int'(N_EP)) begin
          ntgt = endp; e_ts = 4'b0001 << endp; waited = 0;
          nph = (pid == IN) ? PH_WAIT : PH_RX;
        end else begin
          nph = (pid == IN) ? PH_IDLE : PH_DROP;
        end
      end
      step();
      checks++;
      if ({ep_token_strb, active_ep} !== {e_ts, 4'(ntgt)}) begin
        errors++; $display("FAIL rnd%0d_token got=%b/%0d exp=%b/%0d", n, ep_token_strb, active_ep, e_ts, ntgt);
      end
      checks++;
      if ({ep_data_strb, ep_data_end, ep_data_fail} !== {e_ds, e_de, e_df}) begin
        errors++; $display("FAIL rnd%0d_rx got=%b/%b/%b exp=%b/%b/%b", n, ep_data_strb, ep_data_end, ep_data_fail,
          e_ds, e_de, e_df);
      end
      checks++;
      if (ep_pid !== hs.pid_in) begin
        errors++; $display("FAIL rnd%0d_pid got=%h exp=%h", n, ep_pid, hs.pid_in);
      end
      if (e_ds != 4'b0) begin
        checks++;
        if (ep_data !== hs.data_in) begin
          errors++; $display("FAIL rnd%0d_data got=%h exp=%h", n, ep_data, hs.data_in);
        end
      end
      if (e_ts != 4'b0) begin
        checks++;
        if (ep_token !== hs.token_in) begin
          errors++; $display("FAIL rnd%0d_tokval got=%h exp=%h", n, ep_token, hs.token_in);
        end
      end
      ph = nph; tgt = ntgt; pend = e_tf;
    end
    clr_in();
  endtask

  initial begin
    test_reset();
    test_out_rx();
    test_in_tx();
    test_drop();
    test_sof_during_rx();
    test_retry();
    test_tx_wait();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
